// File: rtl/freq_meas_ctrl.sv
// rtl/freq_meas_ctrl.sv - gated rising-edge counter for frequency measurement
// Define FREQ_MEAS_SYNC_EN to insert a 2-flop synchronizer on sig_in.
module freq_meas_ctrl #(
   parameter int unsigned GATE_CYCLES = 100_000_000,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             cont,
   input  logic             sig_in,
   output logic             gate,
   output logic             busy,
   output logic [CNT_W-1:0] result,
   output logic             valid,
   output logic             overflow
);
   typedef enum logic [1:0] {S_IDLE, S_ARM, S_GATE, S_LATCH} state_t;

   state_t            r_state;
   state_t            w_next;
   logic              r_cont;
   logic [31:0]       r_timer;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_ovf;
   logic              r_cur;
   logic              r_prev;
   logic [CNT_W-1:0]  r_result;
   logic              r_overflow;
   logic              r_valid;
   logic              w_samp;
   logic              w_rise;
   logic              w_timer_done;
   logic              w_cnt_max;

`ifdef FREQ_MEAS_SYNC_EN
   logic r_sync1;
   logic r_sync2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= sig_in;
         r_sync2 <= r_sync1;
      end
   end
   assign w_samp = r_sync2;
`else
   assign w_samp = sig_in;
`endif

   assign w_rise       = r_cur & ~r_prev;
   assign w_timer_done = (r_timer == 32'(GATE_CYCLES - 1));
   assign w_cnt_max    = &r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      gate   = 1'b0;
      busy   = 1'b1;
      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (start && !stop) w_next = S_ARM;
         end
         S_ARM:   w_next = stop ? S_IDLE : S_GATE;
         S_GATE: begin
            gate = 1'b1;
            if (stop)              w_next = S_IDLE;
            else if (w_timer_done) w_next = S_LATCH;
         end
         S_LATCH: begin
            if (stop)        w_next = S_IDLE;
            else if (r_cont) w_next = S_ARM;
            else             w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Only edges whose detect cycle is a GATE cycle reach the counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cur      <= 1'b0;
         r_prev     <= 1'b0;
         r_cont     <= 1'b0;
         r_timer    <= '0;
         r_cnt      <= '0;
         r_ovf      <= 1'b0;
         r_result   <= '0;
         r_overflow <= 1'b0;
         r_valid    <= 1'b0;
      end else begin
         r_cur   <= w_samp;
         r_prev  <= r_cur;
         r_valid <= 1'b0;
         if (r_state == S_IDLE && start && !stop) r_cont <= cont;
         case (r_state)
            S_ARM: begin
               r_cnt   <= '0;
               r_ovf   <= 1'b0;
               r_timer <= '0;
            end
            S_GATE: begin
               r_timer <= r_timer + 32'd1;
               if (w_rise) begin
                  if (w_cnt_max) r_ovf <= 1'b1;
                  else           r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
               end
            end
            S_LATCH: begin
               if (!stop) begin
                  r_result   <= r_cnt;
                  r_overflow <= r_ovf;
                  r_valid    <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign result   = r_result;
   assign overflow = r_overflow;
   assign valid    = r_valid;
endmodule

// File: tb/tb_freq_meas_ctrl.sv
// tb/tb_freq_meas_ctrl.sv - scoreboard bench for freq_meas_ctrl
module tb_freq_meas_ctrl;
   localparam int GC = 100;
`ifdef FREQ_MEAS_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   typedef struct {
      logic [31:0] res;
      logic        ovf;
      logic        cont;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0, stop = 1'b0, cont = 1'b0, sig_in = 1'b0;
   logic        gate, busy, valid, overflow;
   logic [31:0] result;
   logic        b_start = 1'b0, b_sig = 1'b0;
   logic        b_gate, b_busy, b_valid, b_ovf;
   logic [3:0]  b_result;

   int   errors = 0, checks = 0, cyc = 0;
   int   n_valid = 0, n_valid4 = 0, gate_run = 0, last_vt = 0, per = 0;
   int   t1, snap;
   bit   b_tog = 1'b0;
   exp_t q[$], q4[$];
   exp_t e_m, e_b;
   int   ks[4] = '{2, 101, 1, 102};
   int   ex[4] = '{1, 1, 0, 0};

   freq_meas_ctrl #(.GATE_CYCLES(GC), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .cont(cont), .sig_in(sig_in),
      .gate(gate), .busy(busy), .result(result), .valid(valid), .overflow(overflow)
   );

   freq_meas_ctrl #(.GATE_CYCLES(GC), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .start(b_start), .stop(1'b0), .cont(1'b0), .sig_in(b_sig),
      .gate(b_gate), .busy(b_busy), .result(b_result), .valid(b_valid), .overflow(b_ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_valid(input bit which, input int budget);
      int s = which ? n_valid4 : n_valid;
      int k = 0;
      while ((which ? n_valid4 : n_valid) == s && k < budget) begin
         tick(1);
         k++;
      end
      chk(which ? "wait_valid4" : "wait_valid", (which ? n_valid4 : n_valid) - s, 1);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   // Scoreboard pop side: every valid must match the oldest pending expectation.
   always @(negedge clk) begin
      if (gate) gate_run++;
      if (valid) begin
         n_valid++;
         last_vt = cyc;
         chk("valid_expected", 32'(q.size() != 0), 1);
         if (q.size() != 0) begin
            e_m = q.pop_front();
            chk("result", result, e_m.res);
            chk("overflow", 32'(overflow), 32'(e_m.ovf));
            chk("busy_at_valid", 32'(busy), 32'(e_m.cont));
            chk("gate_len", gate_run, GC);
         end
         gate_run = 0;
      end
      if (!busy) gate_run = 0;
      if (b_valid) begin
         n_valid4++;
         chk("valid4_expected", 32'(q4.size() != 0), 1);
         if (q4.size() != 0) begin
            e_b = q4.pop_front();
            chk("result4", 32'(b_result), e_b.res);
            chk("overflow4", 32'(b_ovf), 32'(e_b.ovf));
         end
      end
   end

   initial begin
      int ph = 0;
      forever begin
         @(posedge clk);
         #1;
         if (per != 0) begin
            ph++;
            if (ph >= per / 2) begin
               ph = 0;
               sig_in = ~sig_in;
            end
         end
         if (b_tog) b_sig = ~b_sig;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      tick(3);
      chk("rst_gate", 32'(gate), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_valid", 32'(valid), 0);
      chk("rst_result", result, 0);
      chk("rst_overflow", 32'(overflow), 0);
      rst = 1'b0;
      tick(2);

      // single window, period 10
      per = 10;
      tick(7);
      q.push_back('{32'd10, 1'b0, 1'b0});
      pulse_start();
      wait_valid(1'b0, 300);
      tick(2);
      chk("idle_after_single", 32'(busy), 0);

      // start and stop together: stop wins
      start = 1'b1;
      stop  = 1'b1;
      tick(1);
      start = 1'b0;
      stop  = 1'b0;
      chk("start_stop_busy0", 32'(busy), 0);
      tick(1);
      chk("start_stop_busy1", 32'(busy), 0);

      // start during GATE is ignored
      per = 4;
      tick(6);
      q.push_back('{32'd25, 1'b0, 1'b0});
      pulse_start();
      tick(50);
      pulse_start();
      wait_valid(1'b0, 200);
      snap = n_valid;
      tick(150);
      chk("no_restart_busy", 32'(busy), 0);
      chk("no_restart_valid", n_valid - snap, 0);

      // continuous mode, then stop mid-window
      repeat (3) q.push_back('{32'd25, 1'b0, 1'b1});
      cont = 1'b1;
      pulse_start();
      cont = 1'b0;
      wait_valid(1'b0, 300);
      t1 = last_vt;
      wait_valid(1'b0, 200);
      chk("cont_period1", last_vt - t1, GC + 2);
      t1 = last_vt;
      wait_valid(1'b0, 200);
      chk("cont_period2", last_vt - t1, GC + 2);
      tick(50);
      stop = 1'b1;
      tick(1);
      stop = 1'b0;
      tick(1);
      chk("stop_idle", 32'(busy), 0);
      snap = n_valid;
      tick(200);
      chk("stop_no_valid", n_valid - snap, 0);
      chk("stop_result_kept", result, 25);

      // saturation on the narrow instance, then a clean zero run
      b_tog = 1'b1;
      tick(3);
      q4.push_back('{32'd15, 1'b1, 1'b0});
      b_start = 1'b1;
      tick(1);
      b_start = 1'b0;
      wait_valid(1'b1, 300);
      b_tog = 1'b0;
      b_sig = 1'b0;
      tick(5);
      q4.push_back('{32'd0, 1'b0, 1'b0});
      b_start = 1'b1;
      tick(1);
      b_start = 1'b0;
      wait_valid(1'b1, 300);

      // asynchronous reset mid-window
      per = 10;
      tick(5);
      pulse_start();
      tick(51);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_gate", 32'(gate), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_valid", 32'(valid), 0);
      chk("mid_rst_result", result, 0);
      chk("mid_rst_overflow", 32'(overflow), 0);
      tick(3);
      rst = 1'b0;
      snap = n_valid;
      tick(200);
      chk("post_rst_no_valid", n_valid - snap, 0);
      chk("post_rst_busy", 32'(busy), 0);

      // single rise detected at window boundaries
      per = 0;
      sig_in = 1'b0;
      tick(6);
      for (int i = 0; i < 4; i++) begin
         snap = n_valid;
         q.push_back('{32'(ex[i]), 1'b0, 1'b0});
         for (int j = -5; j <= 110; j++) begin
            tick(1);
            start = (j == 0);
            if (j == ks[i] - LAT)     sig_in = 1'b1;
            if (j == ks[i] - LAT + 2) sig_in = 1'b0;
         end
         start = 1'b0;
         tick(5);
         chk("boundary_valid", n_valid - snap, 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/freq_meas_ctrl.md
FREQ_MEAS_CTRL -- requirements
Module: freq_meas_ctrl

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 100_000_000, gate window length in clk cycles (1 s at 100 MHz), legal range 2..2^32-1.
REQ-002 SHALL have parameter CNT_W, default 32, width of edge counter and result.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a measurement.
REQ-006 SHALL have port stop  input  1  abort current measurement or continuous run.
REQ-007 SHALL have port cont  input  1  continuous mode, sampled in IDLE when start is accepted.
REQ-008 SHALL have port sig_in  input  1  measured signal, asynchronous to clk.
REQ-009 SHALL have port gate  output  1  high exactly while the window is open (state GATE).
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port result  output  CNT_W  rising-edge count of the last completed window.
REQ-012 SHALL have port valid  output  1  one-cycle pulse when result updates.
REQ-013 SHALL have port overflow  output  1  the count in result saturated.

Function
REQ-014 SHALL implement states IDLE, ARM, GATE, LATCH.
REQ-015 IDLE->ARM SHALL occur on start=1 and stop=0; start in any other state SHALL be ignored.
REQ-016 ARM SHALL last 1 cycle, clear the edge counter and the window timer, then go to GATE.
REQ-017 GATE SHALL last exactly GATE_CYCLES cycles, then go to LATCH.
REQ-018 In GATE, a rising edge of the sampled signal (registered previous 0, current 1) SHALL increment the edge counter by 1.
REQ-019 The edge counter SHALL saturate at 2^CNT_W-1. Edges after saturation SHALL set an internal ovf flag and SHALL NOT wrap.
REQ-020 An edge detected in the last GATE cycle SHALL be counted. Edges detected in ARM or LATCH SHALL NOT be counted.
REQ-021 LATCH SHALL last 1 cycle, copy the counter to result and ovf to overflow, and pulse valid=1 in the same cycle.
REQ-022 From LATCH the block SHALL go to ARM if the latched cont=1, and to IDLE otherwise.
REQ-023 In continuous mode the gap between consecutive windows SHALL be 2 cycles (LATCH, ARM).
REQ-024 stop=1 in ARM, GATE or LATCH SHALL force IDLE on the next edge. valid SHALL NOT pulse in that cycle, and result and overflow SHALL keep their values.
REQ-025 If start and stop are both 1 in IDLE, stop SHALL win and the block SHALL stay in IDLE.
REQ-026 result and overflow SHALL change only in LATCH.

Reset
REQ-027 rst=1 SHALL immediately force IDLE, gate=0, busy=0, valid=0, result=0, overflow=0, edge counter=0, timer=0, and all sampling flops=0.
REQ-028 rst asserted mid-window SHALL discard the measurement. After release the block SHALL wait in IDLE for start.

Configuration
REQ-029 The macro FREQ_MEAS_SYNC_EN SHALL control the input synchronizer.
REQ-030 With FREQ_MEAS_SYNC_EN defined, sig_in SHALL pass through a 2-flop synchronizer before the edge-detect register, giving 3 cycles from a sig_in rise to the count increment.
REQ-031 Without FREQ_MEAS_SYNC_EN, sig_in SHALL feed the edge-detect register directly, giving 1 cycle from a sig_in rise to the count increment. The caller then guarantees sig_in is synchronous to clk.

Verification
REQ-032 GATE_CYCLES=100, sig_in toggling every 5 clk (period 10), start pulse -> gate high 100 cycles, valid pulses once, result=10, overflow=0, busy low 1 cycle after LATCH.
REQ-033 GATE_CYCLES=100, cont=1, sig_in period 4 clk -> valid every 102 cycles, result=25 each window, stop mid-window -> IDLE, no extra valid, result stays 25.
REQ-034 CNT_W=4, GATE_CYCLES=100, sig_in period 2 clk -> result=15, overflow=1. A following run with sig_in held at 0 -> result=0, overflow=0.
REQ-035 rst pulsed at cycle 50 of the window -> all outputs 0 during reset. With no new start, valid stays 0 for 200 cycles.
REQ-036 start and stop together in IDLE -> busy stays 0. start during GATE -> ignored, the window ends at GATE_CYCLES as normal.
REQ-037 A single sig_in rise placed so it is detected in the last GATE cycle -> counted (result=1). A rise detected in the ARM cycle -> not counted (result=0). Check both with and without FREQ_MEAS_SYNC_EN.
